// File: rtl/mem_wb_stage.sv
// Memory-response / writeback stage: retires ALU and link results directly and waits for load data.
// Optional build macro WB_MISALIGN_CHECK_EN turns misaligned half/word loads into misalign_err pulses.
module mem_wb_stage #(
  parameter int XLEN         = 32,
  parameter int RF_AW        = 5,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             valid_in,
  input  logic [XLEN-1:0]  alu_out,
  input  logic [RF_AW-1:0] rd_in,
  input  logic [XLEN-1:0]  pc_pls4_in,
  input  logic             ctrl_reg_wr_in,
  input  logic [1:0]       ctrl_wb_sel_in,
  input  logic             ld_unsigned_in,
  input  logic [1:0]       ld_n_bytes_in,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             stall_out,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             load_timeout,
  output logic             misalign_err,
  output logic [31:0]      retire_cnt
);

  localparam logic [1:0] WB_DMEM    = 2'd1;
  localparam logic [1:0] WB_PC_PLS4 = 2'd2;
  localparam int         TW         = (LOAD_TIMEOUT > 0) ? $clog2(LOAD_TIMEOUT + 1) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TW-1:0]    r_to_cnt;

  logic [RF_AW-1:0] r_ld_rd_p0;
  logic             r_ld_wr_p0;
  logic [1:0]       r_ld_addr_p0;
  logic [1:0]       r_ld_size_p0;
  logic             r_ld_uns_p0;

  logic             r_rf_we_p1;
  logic [RF_AW-1:0] r_rf_waddr_p1;
  logic [XLEN-1:0]  r_rf_wdata_p1;
  logic             r_load_to_p1;
  logic             r_misalign_p1;
  logic [31:0]      r_retire_p1;

  logic             w_accept;
  logic             w_is_load;
  logic             w_ld_done;
  logic             w_timeout;
  logic             w_misalign;

  function automatic logic [XLEN-1:0] f_load_extend(input logic [XLEN-1:0] raw,
                                                    input logic [1:0]      addr,
                                                    input logic [1:0]      size,
                                                    input logic            uns);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh  = raw;
    res = raw;
    case (size)
      2'd0: begin
        sh  = raw >> {addr, 3'b000};
        res = {{(XLEN-8){sh[7] & ~uns}}, sh[7:0]};
      end
      2'd1: begin
        sh  = raw >> {addr[1], 4'b0000};
        res = {{(XLEN-16){sh[15] & ~uns}}, sh[15:0]};
      end
      default: res = raw;
    endcase
    return res;
  endfunction

`ifdef WB_MISALIGN_CHECK_EN
  function automatic logic f_misaligned(input logic [1:0] addr, input logic [1:0] size);
    return ((size == 2'd1) && addr[0]) || (size[1] && (addr != 2'd0));
  endfunction

  assign w_misalign = w_ld_done & f_misaligned(r_ld_addr_p0, r_ld_size_p0);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept  = (r_state == S_IDLE) & valid_in;
  assign w_is_load = (ctrl_wb_sel_in == WB_DMEM);
  assign w_ld_done = (r_state == S_WAIT) & dmem_rvalid;
  // A response arriving in the final allowed cycle still completes the load.
  assign w_timeout = (r_state == S_WAIT) & ~dmem_rvalid & (LOAD_TIMEOUT != 0) &
                     (r_to_cnt == TW'(LOAD_TIMEOUT));
  assign stall_out = (r_state == S_WAIT) & ~dmem_rvalid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_load)    w_state_nxt = S_WAIT;
      S_WAIT:  if (w_ld_done || w_timeout)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // p0: capture of the outstanding load's attributes
  always_ff @(posedge clk) begin
    if (w_accept && w_is_load) begin
      r_ld_rd_p0   <= rd_in;
      r_ld_wr_p0   <= ctrl_reg_wr_in;
      r_ld_addr_p0 <= alu_out[1:0];
      r_ld_size_p0 <= ld_n_bytes_in;
      r_ld_uns_p0  <= ld_unsigned_in;
    end
  end

  // p1: register-file write port, status pulses and retire count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_to_cnt      <= '0;
      r_rf_we_p1    <= 1'b0;
      r_rf_waddr_p1 <= '0;
      r_rf_wdata_p1 <= '0;
      r_load_to_p1  <= 1'b0;
      r_misalign_p1 <= 1'b0;
      r_retire_p1   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_rf_we_p1    <= 1'b0;
      r_load_to_p1  <= w_timeout;
      r_misalign_p1 <= w_misalign;
      if (w_accept && w_is_load) begin
        r_to_cnt <= TW'(1);
      end else if (r_state == S_WAIT) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_accept && !w_is_load) begin
        r_rf_we_p1    <= ctrl_reg_wr_in & (rd_in != '0);
        r_rf_waddr_p1 <= rd_in;
        r_rf_wdata_p1 <= (ctrl_wb_sel_in == WB_PC_PLS4) ? pc_pls4_in : alu_out;
        r_retire_p1   <= r_retire_p1 + 32'd1;
      end else if (w_ld_done && !w_misalign) begin
        r_rf_we_p1    <= r_ld_wr_p0 & (r_ld_rd_p0 != '0);
        r_rf_waddr_p1 <= r_ld_rd_p0;
        r_rf_wdata_p1 <= f_load_extend(dmem_rdata, r_ld_addr_p0, r_ld_size_p0, r_ld_uns_p0);
        r_retire_p1   <= r_retire_p1 + 32'd1;
      end
    end
  end

  assign rf_we        = r_rf_we_p1;
  assign rf_waddr     = r_rf_waddr_p1;
  assign rf_wdata     = r_rf_wdata_p1;
  assign load_timeout = r_load_to_p1;
  assign misalign_err = r_misalign_p1;
  assign retire_cnt   = r_retire_p1;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed cases with literal expectations, then randomized traffic
// compared every cycle against an instruction-level model of the writeback stage.
module tb_mem_wb_stage;

  localparam int TO = 16;
`ifdef WB_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid_in;
  logic [31:0] alu_out;
  logic [4:0]  rd_in;
  logic [31:0] pc_pls4_in;
  logic        ctrl_reg_wr_in;
  logic [1:0]  ctrl_wb_sel_in;
  logic        ld_unsigned_in;
  logic [1:0]  ld_n_bytes_in;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall_out;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_timeout;
  logic        misalign_err;
  logic [31:0] retire_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // model state: one pending load at most, plus the outputs expected after the last edge
  logic        m_busy;
  int          m_wait;
  logic [4:0]  m_ld_rd;
  logic        m_ld_wr;
  logic [1:0]  m_ld_a;
  logic [1:0]  m_ld_nb;
  logic        m_ld_u;
  logic        m_we;
  logic        m_to;
  logic        m_mis;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_ret;

  mem_wb_stage #(.XLEN(32), .RF_AW(5), .LOAD_TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .alu_out(alu_out), .rd_in(rd_in),
    .pc_pls4_in(pc_pls4_in), .ctrl_reg_wr_in(ctrl_reg_wr_in), .ctrl_wb_sel_in(ctrl_wb_sel_in),
    .ld_unsigned_in(ld_unsigned_in), .ld_n_bytes_in(ld_n_bytes_in), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .stall_out(stall_out), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .load_timeout(load_timeout), .misalign_err(misalign_err),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_value(input logic [31:0] raw, input logic [1:0] a,
                                           input logic [1:0] nb, input logic u);
    logic [31:0] v;
    if (nb == 2'd0) begin
      v = (raw >> (8 * a)) & 32'h0000_00FF;
      if (!u && v[7]) v = v | 32'hFFFF_FF00;
    end else if (nb == 2'd1) begin
      v = (raw >> (16 * a[1])) & 32'h0000_FFFF;
      if (!u && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = raw;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_wait = 0; m_we = 1'b0; m_to = 1'b0; m_mis = 1'b0;
    m_waddr = '0; m_wdata = '0; m_ret = '0;
  endtask

  task automatic model_step();
    logic mis;
    m_we = 1'b0; m_to = 1'b0; m_mis = 1'b0;
    if (!m_busy) begin
      if (valid_in) begin
        if (ctrl_wb_sel_in == 2'd1) begin
          m_busy = 1'b1; m_wait = 0;
          m_ld_rd = rd_in; m_ld_wr = ctrl_reg_wr_in; m_ld_a = alu_out[1:0];
          m_ld_nb = ld_n_bytes_in; m_ld_u = ld_unsigned_in;
        end else begin
          m_we    = ctrl_reg_wr_in && (rd_in != 0);
          m_waddr = rd_in;
          m_wdata = (ctrl_wb_sel_in == 2'd2) ? pc_pls4_in : alu_out;
          m_ret   = m_ret + 1;
        end
      end
    end else begin
      m_wait++;
      if (dmem_rvalid) begin
        m_busy = 1'b0;
        mis = ((m_ld_nb == 2'd1) && m_ld_a[0]) || ((m_ld_nb >= 2'd2) && (m_ld_a != 2'd0));
        if (MIS_EN && mis) begin
          m_mis = 1'b1;
        end else begin
          m_we    = m_ld_wr && (m_ld_rd != 0);
          m_waddr = m_ld_rd;
          m_wdata = ld_value(dmem_rdata, m_ld_a, m_ld_nb, m_ld_u);
          m_ret   = m_ret + 1;
        end
      end else if (TO != 0 && m_wait == TO) begin
        m_busy = 1'b0;
        m_to   = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    check("stall_out", 32'(stall_out), 32'(m_busy && !dmem_rvalid && rstn));
    check("rf_we", 32'(rf_we), 32'(m_we));
    check("load_timeout", 32'(load_timeout), 32'(m_to));
    check("misalign_err", 32'(misalign_err), 32'(m_mis));
    check("retire_cnt", retire_cnt, m_ret);
    if (m_we || !rstn) begin
      check("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
      check("rf_wdata", rf_wdata, m_wdata);
    end
  end

  task automatic cycle();
    @(posedge clk);
    if (rstn) model_step();
    #1;
  endtask

  task automatic quiet();
    valid_in = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] pc, input logic wr, input logic u, input logic [1:0] nb);
    valid_in = 1'b1; ctrl_wb_sel_in = sel; rd_in = rd; alu_out = alu; pc_pls4_in = pc;
    ctrl_reg_wr_in = wr; ld_unsigned_in = u; ld_n_bytes_in = nb; dmem_rvalid = 1'b0;
  endtask

  task automatic load_txn(input logic [4:0] rd, input logic [31:0] addr, input logic [1:0] nb,
                          input logic u, input logic [31:0] raw, input int nwait);
    issue(2'd1, rd, addr, 32'h0, 1'b1, u, nb);
    cycle();
    quiet();
    repeat (nwait) begin
      #1;
      check("ld_wait_stall", 32'(stall_out), 32'd1);
      cycle();
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = raw;
    #1;
    check("ld_rvalid_stall", 32'(stall_out), 32'd0);
    cycle();
    quiet();
  endtask

  task automatic do_reset();
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check("rst_stall", 32'(stall_out), 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_retire", retire_cnt, 32'd0);
    quiet();
    cycle();
    cycle();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    model_reset();
    quiet();
    issue(2'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0);
    valid_in = 1'b0;
    dmem_rdata = '0;
    repeat (3) cycle();
    check("reset_we", 32'(rf_we), 32'd0);
    check("reset_stall", 32'(stall_out), 32'd0);
    check("reset_retire", retire_cnt, 32'd0);
    check("reset_waddr", 32'(rf_waddr), 32'd0);
    check("reset_wdata", rf_wdata, 32'd0);
    check("reset_to", 32'(load_timeout), 32'd0);
    check("reset_mis", 32'(misalign_err), 32'd0);
    rstn = 1'b1;
    cycle();

    issue(2'd0, 5'd5, 32'h0000_1234, 32'h0000_0040, 1'b1, 1'b0, 2'd2);
    cycle();
    check("alu_we", 32'(rf_we), 32'd1);
    check("alu_waddr", 32'(rf_waddr), 32'd5);
    check("alu_wdata", rf_wdata, 32'h0000_1234);
    check("alu_retire", retire_cnt, 32'd1);
    check("model_alu", m_wdata, 32'h0000_1234);
    issue(2'd2, 5'd1, 32'h0000_DEAD, 32'h0000_1004, 1'b1, 1'b0, 2'd2);
    cycle();
    check("jal_wdata", rf_wdata, 32'h0000_1004);
    check("jal_retire", retire_cnt, 32'd2);
    issue(2'd0, 5'd6, 32'h0000_0077, 32'h0, 1'b0, 1'b0, 2'd2);
    cycle();
    quiet();
    check("nowr_we", 32'(rf_we), 32'd0);
    check("nowr_retire", retire_cnt, 32'd3);

    load_txn(5'd7, 32'h0000_1003, 2'd0, 1'b0, 32'h80FF_0000, 3);
    check("lb_we", 32'(rf_we), 32'd1);
    check("lb_waddr", 32'(rf_waddr), 32'd7);
    check("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    check("lb_retire", retire_cnt, 32'd4);
    check("model_lb", m_wdata, 32'hFFFF_FF80);
    load_txn(5'd7, 32'h0000_1003, 2'd0, 1'b1, 32'h80FF_0000, 3);
    check("lbu_wdata", rf_wdata, 32'h0000_0080);
    check("lbu_retire", retire_cnt, 32'd5);
    load_txn(5'd3, 32'h0000_2002, 2'd1, 1'b0, 32'hBEEF_0000, 0);
    check("lh_wdata", rf_wdata, 32'hFFFF_BEEF);
    check("lh_retire", retire_cnt, 32'd6);
    load_txn(5'd0, 32'h0000_2002, 2'd1, 1'b0, 32'hBEEF_0000, 1);
    check("lh_rd0_we", 32'(rf_we), 32'd0);
    check("lh_rd0_retire", retire_cnt, 32'd7);

    issue(2'd1, 5'd9, 32'h0000_3000, 32'h0, 1'b1, 1'b0, 2'd2);
    cycle();
    quiet();
    repeat (TO) begin
      #1;
      check("to_stall", 32'(stall_out), 32'd1);
      cycle();
    end
    check("to_pulse", 32'(load_timeout), 32'd1);
    check("to_we", 32'(rf_we), 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_2222;
    #1;
    check("late_stall", 32'(stall_out), 32'd0);
    cycle();
    quiet();
    check("late_we", 32'(rf_we), 32'd0);
    check("late_to", 32'(load_timeout), 32'd0);
    check("late_retire", retire_cnt, 32'd7);

    load_txn(5'd10, 32'h0000_4000, 2'd2, 1'b0, 32'h1357_9BDF, TO - 1);
    check("edge_to", 32'(load_timeout), 32'd0);
    check("edge_wdata", rf_wdata, 32'h1357_9BDF);
    check("edge_retire", retire_cnt, 32'd8);

    load_txn(5'd4, 32'h0000_5002, 2'd2, 1'b0, 32'hCAFE_F00D, 1);
`ifdef WB_MISALIGN_CHECK_EN
    check("lw_mis_err", 32'(misalign_err), 32'd1);
    check("lw_mis_we", 32'(rf_we), 32'd0);
    check("lw_mis_retire", retire_cnt, 32'd8);
`else
    check("lw_mis_err", 32'(misalign_err), 32'd0);
    check("lw_mis_wdata", rf_wdata, 32'hCAFE_F00D);
    check("lw_mis_retire", retire_cnt, 32'd9);
`endif

    issue(2'd1, 5'd12, 32'h0000_6000, 32'h0, 1'b1, 1'b0, 2'd2);
    cycle();
    quiet();
    cycle();
    do_reset();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    cycle();
    quiet();
    check("post_rst_we", 32'(rf_we), 32'd0);
    check("post_rst_retire", retire_cnt, 32'd0);

    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        do_reset();
      end else begin
        valid_in       = ($urandom_range(0, 1) == 1);
        ctrl_wb_sel_in = 2'($urandom_range(0, 3));
        rd_in          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        alu_out        = $urandom;
        pc_pls4_in     = $urandom;
        ctrl_reg_wr_in = ($urandom_range(0, 3) != 0);
        ld_unsigned_in = ($urandom_range(0, 1) == 1);
        ld_n_bytes_in  = 2'($urandom_range(0, 3));
        dmem_rvalid    = m_busy ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 15) == 0);
        dmem_rdata     = $urandom;
        cycle();
      end
    end
    quiet();
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
